// File: rtl/pcpu_mem_pkg.sv
// Shared constants for the pcpu memory subsystem: opcodes, FSM states and
// the legal data-read latency range.
package pcpu_mem_pkg;

  typedef enum logic [4:0] {
    OP_NOP   = 5'b00000,
    OP_HALT  = 5'b00001,
    OP_LOAD  = 5'b00010,
    OP_STORE = 5'b00011
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Out-of-range latencies are pulled into the supported window.
  function automatic int clamp_lat(input int lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/pcpu_mem_sys_if.sv
// Host preload port, run/start handshake and CPU fetch/data bus of the
// pcpu memory subsystem. slave = memory subsystem, master = host/CPU side.
interface pcpu_mem_sys_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  logic              prog_valid;
  logic              prog_ready;
  logic              prog_sel;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              run;
  logic              cpu_start;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_datain;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_dataout;
  logic              d_we;
  logic [DATA_W-1:0] d_datain;
  logic              halted;
  logic [CNT_W-1:0]  cycle_count;
  logic              prot_err;

  modport slave (
    input  prog_valid, prog_sel, prog_addr, prog_data, run,
           i_addr, d_addr, d_dataout, d_we,
    output prog_ready, cpu_start, i_datain, d_datain, halted, cycle_count, prot_err
  );

  modport master (
    output prog_valid, prog_sel, prog_addr, prog_data, run,
           i_addr, d_addr, d_dataout, d_we,
    input  prog_ready, cpu_start, i_datain, d_datain, halted, cycle_count, prot_err
  );
endinterface

// File: rtl/pcpu_mem_rdpipe.sv
// DATA_W x RD_LAT delay line carrying load data to the CPU; flush zeroes
// every stage so no stale data survives a run boundary.
module pcpu_mem_rdpipe #(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);
  logic [RD_LAT-1:0][DATA_W-1:0] r_pipe;

  // Shift one stage per edge, or clear all stages on flush.
  always_ff @(posedge clock) begin
    if (i_flush) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_data;
      for (int s = 1; s < RD_LAT; s++) r_pipe[s] <= r_pipe[s-1];
    end
  end

  assign o_data = r_pipe[RD_LAT-1];
endmodule

// File: rtl/pcpu_mem_sys.sv
// Instruction/data memory subsystem for pcpu: host preload, run/halt
// sequencing, fetch and load/store service, frozen cycle counter.
// Optional store protection below PROT_BASE: define PCPU_MEM_PROT_EN.
module pcpu_mem_sys
  import pcpu_mem_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256,
  parameter int RD_LAT     = 1,
  parameter int CNT_W      = 16,
  parameter int PROT_BASE  = 16
) (
  input logic           clock,
  input logic           reset,
  pcpu_mem_sys_if.slave bus
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam int LAT = clamp_lat(RD_LAT);

  logic [DATA_W-1:0] r_imem [IMEM_DEPTH];
  logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];

  state_e            r_state;
  logic              r_prog_ready;
  logic              r_cpu_start;
  logic              r_halted;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_prog_fire, w_pi_ok, w_pd_ok, w_i_ok, w_d_ok;
  logic              w_halt_det, w_store, w_prot_hit, w_flush;
  logic [DATA_W-1:0] w_fetch, w_rd, w_rd_q;

  assign w_prog_fire = !reset && bus.prog_valid && r_prog_ready;
  assign w_pi_ok     = int'(bus.prog_addr) < IMEM_DEPTH;
  assign w_pd_ok     = int'(bus.prog_addr) < DMEM_DEPTH;
  assign w_i_ok      = int'(bus.i_addr) < IMEM_DEPTH;
  assign w_d_ok      = int'(bus.d_addr) < DMEM_DEPTH;

  // Fetch is NOP outside RUN so the CPU idles harmlessly.
  assign w_fetch    = (r_state == ST_RUN && w_i_ok) ? r_imem[bus.i_addr[IAW-1:0]] : '0;
  assign w_halt_det = (r_state == ST_RUN) && (w_fetch[DATA_W-1 -: 5] == OP_HALT);
  assign w_store    = !reset && (r_state == ST_RUN) && bus.d_we && w_d_ok && !w_prot_hit;

  // Run/halt sequencing with registered handshake, start pulse and counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_prog_ready <= 1'b0;
      r_cpu_start  <= 1'b0;
      r_halted     <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_cpu_start <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.run) begin
            r_state      <= ST_RUN;
            r_cpu_start  <= 1'b1;
            r_prog_ready <= 1'b0;
          end else begin
            r_prog_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          if (w_halt_det) begin
            r_state      <= ST_HALTED;
            r_halted     <= 1'b1;
            r_prog_ready <= 1'b1;
          end
        end
        ST_HALTED: begin
          r_prog_ready <= 1'b1;
          if (bus.run) begin
            r_state  <= ST_IDLE;
            r_halted <= 1'b0;
            r_cnt    <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Instruction memory: host writes only; out-of-range addresses dropped.
  always_ff @(posedge clock) begin
    if (w_prog_fire && !bus.prog_sel && w_pi_ok) r_imem[bus.prog_addr[IAW-1:0]] <= bus.prog_data;
  end

  // Data memory: host and CPU never collide since prog_ready is low in RUN.
  always_ff @(posedge clock) begin
    if (w_prog_fire && bus.prog_sel && w_pd_ok) r_dmem[bus.prog_addr[DAW-1:0]] <= bus.prog_data;
    else if (w_store)                            r_dmem[bus.d_addr[DAW-1:0]]    <= bus.d_dataout;
  end

`ifdef PCPU_MEM_PROT_EN
  logic r_prot_err;
  assign w_prot_hit = int'(bus.d_addr) < PROT_BASE;

  // Sticky flag for any CPU store into the protected low region.
  always_ff @(posedge clock) begin
    if (reset)                                              r_prot_err <= 1'b0;
    else if (r_state == ST_RUN && bus.d_we && w_prot_hit)   r_prot_err <= 1'b1;
  end
  assign bus.prot_err = r_prot_err;
`else
  // No protected region in this build; PROT_BASE is never negative.
  assign w_prot_hit   = (PROT_BASE < 0);
  assign bus.prot_err = 1'b0;
`endif

  // Read samples before the same-edge store, so a colliding load sees old data.
  assign w_rd    = w_d_ok ? r_dmem[bus.d_addr[DAW-1:0]] : '0;
  assign w_flush = reset || (r_state != ST_RUN) || w_halt_det;

  pcpu_mem_rdpipe #(.DATA_W(DATA_W), .RD_LAT(LAT)) u_rdpipe (
    .clock  (clock),
    .i_flush(w_flush),
    .i_data (w_rd),
    .o_data (w_rd_q)
  );

  assign bus.d_datain    = w_rd_q;
  assign bus.i_datain    = w_fetch;
  assign bus.prog_ready  = r_prog_ready;
  assign bus.cpu_start   = r_cpu_start;
  assign bus.halted      = r_halted;
  assign bus.cycle_count = r_cnt;
endmodule

// File: tb/tb_pcpu_mem_sys.sv
// Randomized bench for pcpu_mem_sys: the bench plays host and CPU, and a
// reference of both memories plus a load-history queue predicts every output.
module tb_pcpu_mem_sys;
  localparam int DW = 16, AW = 8, IMEM_D = 128, DMEM_D = 256, RD_LAT = 3, CW = 6, PROT_BASE = 16;
  localparam logic [4:0] HALT_OP = 5'b00001;
`ifdef PCPU_MEM_PROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;

  pcpu_mem_sys_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();
  pcpu_mem_sys #(.DATA_W(DW), .ADDR_W(AW), .IMEM_DEPTH(IMEM_D), .DMEM_DEPTH(DMEM_D),
                 .RD_LAT(RD_LAT), .CNT_W(CW), .PROT_BASE(PROT_BASE))
    dut (.clock(clock), .reset(reset), .bus(bus));

  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] imem_m [IMEM_D];
  logic [DW-1:0] dmem_m [DMEM_D];
  bit perr_m = 0;
  logic [AW-1:0] s_iaddr [128];
  logic [AW-1:0] s_daddr [128];
  logic          s_we    [128];
  logic [DW-1:0] s_dout  [128];

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w = 16'($urandom);
    if (w[15:11] == HALT_OP) w[15:11] = 5'b00010;
    return w;
  endfunction

  task automatic host_wr(input logic sel, input int addr, input logic [DW-1:0] data);
    bus.prog_valid = 1'b1; bus.prog_sel = sel; bus.prog_addr = addr[AW-1:0]; bus.prog_data = data;
    for (int t = 0; t < 4 && bus.prog_ready !== 1'b1; t++) begin @(posedge clock); #1; end
    n_tests++; if (bus.prog_ready !== 1'b1) begin n_fail++; $display("FAIL host_wr_ready addr=%0h got %b exp 1", addr, bus.prog_ready); end
    @(posedge clock); #1;
    bus.prog_valid = 1'b0;
    if (!sel && addr < IMEM_D) imem_m[addr] = data;
    else if (sel && addr < DMEM_D) dmem_m[addr] = data;
  endtask

  // Program of h non-HALT words followed by HALT at address h.
  task automatic load_prog(input int h);
    for (int i = 0; i < h; i++) host_wr(1'b0, i, rnd_word());
    host_wr(1'b0, h, {HALT_OP, 11'($urandom)});
  endtask

  // Sequential fetch; random loads; optional stores (kept out of the low region unless low_ok).
  task automatic script_default(input bit we_en, input bit low_ok);
    for (int k = 0; k < 128; k++) begin
      s_iaddr[k] = k[AW-1:0];
      s_we[k]    = we_en && ($urandom_range(0, 3) == 0);
      s_daddr[k] = s_we[k] && !low_ok ? 8'($urandom_range(32, 255)) : 8'($urandom);
      s_dout[k]  = 16'($urandom);
    end
  endtask

  task automatic run_cpu(input string tag, input int max_cyc, input bit expect_halt, input bit spam,
                         input bit cw_en, input logic [AW-1:0] cw_addr, input logic [DW-1:0] cw_data,
                         output int ncyc);
    logic [DW-1:0] hist[$];
    logic [DW-1:0] f_exp, r_exp;
    logic [CW-1:0] c_exp;
    bit done = 0;
    int k = 0;
    bus.run = 1'b1;
    if (cw_en) begin bus.prog_valid = 1'b1; bus.prog_sel = 1'b1; bus.prog_addr = cw_addr; bus.prog_data = cw_data; end
    @(posedge clock); #1;
    bus.run = 1'b0; bus.prog_valid = 1'b0;
    if (cw_en) dmem_m[cw_addr] = cw_data;
    while (!done && k < max_cyc) begin
      bus.i_addr = s_iaddr[k]; bus.d_addr = s_daddr[k]; bus.d_we = s_we[k]; bus.d_dataout = s_dout[k];
      if (spam) begin
        bus.prog_valid = 1'b1; bus.prog_sel = 1'($urandom); bus.prog_addr = 8'($urandom_range(0, 12)); bus.prog_data = 16'($urandom);
      end
      #1;
      f_exp = (s_iaddr[k] < IMEM_D) ? imem_m[s_iaddr[k]] : '0;
      r_exp = (k >= RD_LAT) ? hist[k-RD_LAT] : '0;
      c_exp = (k > 63) ? 6'd63 : 6'(k);
      n_tests++; if (bus.i_datain !== f_exp) begin n_fail++; $display("FAIL %s i_datain k=%0d got %h exp %h", tag, k, bus.i_datain, f_exp); end
      n_tests++; if (bus.d_datain !== r_exp) begin n_fail++; $display("FAIL %s d_datain k=%0d got %h exp %h", tag, k, bus.d_datain, r_exp); end
      n_tests++; if (bus.cpu_start !== (k == 0)) begin n_fail++; $display("FAIL %s cpu_start k=%0d got %b exp %b", tag, k, bus.cpu_start, (k == 0)); end
      n_tests++; if (bus.cycle_count !== c_exp) begin n_fail++; $display("FAIL %s cycle_count k=%0d got %0d exp %0d", tag, k, bus.cycle_count, c_exp); end
      n_tests++; if (bus.halted !== 1'b0 || bus.prog_ready !== 1'b0) begin n_fail++; $display("FAIL %s run_flags k=%0d halted=%b ready=%b exp 0 0", tag, k, bus.halted, bus.prog_ready); end
      n_tests++; if (bus.prot_err !== perr_m) begin n_fail++; $display("FAIL %s prot_err k=%0d got %b exp %b", tag, k, bus.prot_err, perr_m); end
      hist.push_back(s_daddr[k] < DMEM_D ? dmem_m[s_daddr[k]] : '0);
      if (s_we[k]) begin
        if (PROT && s_daddr[k] < PROT_BASE) perr_m = 1'b1;
        else if (s_daddr[k] < DMEM_D) dmem_m[s_daddr[k]] = s_dout[k];
      end
      if (f_exp[15:11] == HALT_OP) done = 1;
      @(posedge clock); #1;
      k++;
    end
    bus.prog_valid = 1'b0; bus.d_we = 1'b0;
    ncyc = k;
    n_tests++; if (done !== expect_halt) begin n_fail++; $display("FAIL %s halt_seen got %b exp %b", tag, done, expect_halt); end
  endtask

  task automatic check_halted(input string tag, input int ncyc);
    logic [CW-1:0] c_exp = (ncyc > 63) ? 6'd63 : 6'(ncyc);
    bus.i_addr = '0; bus.d_addr = '0;
    #1;
    n_tests++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL %s halted got %b exp 1", tag, bus.halted); end
    n_tests++; if (bus.cycle_count !== c_exp) begin n_fail++; $display("FAIL %s final_count got %0d exp %0d", tag, bus.cycle_count, c_exp); end
    n_tests++; if (bus.prog_ready !== 1'b1) begin n_fail++; $display("FAIL %s halted_ready got %b exp 1", tag, bus.prog_ready); end
    n_tests++; if (bus.i_datain !== '0 || bus.d_datain !== '0) begin n_fail++; $display("FAIL %s halted_data got %h/%h exp 0/0", tag, bus.i_datain, bus.d_datain); end
    repeat (3) @(posedge clock);
    #1;
    n_tests++; if (bus.cycle_count !== c_exp) begin n_fail++; $display("FAIL %s frozen_count got %0d exp %0d", tag, bus.cycle_count, c_exp); end
  endtask

  task automatic go_idle(input string tag);
    bus.run = 1'b1; @(posedge clock); #1; bus.run = 1'b0;
    n_tests++; if (bus.cpu_start !== 1'b0 || bus.halted !== 1'b0) begin n_fail++; $display("FAIL %s to_idle start=%b halted=%b exp 0 0", tag, bus.cpu_start, bus.halted); end
    n_tests++; if (bus.cycle_count !== '0) begin n_fail++; $display("FAIL %s idle_count got %0d exp 0", tag, bus.cycle_count); end
  endtask

  task automatic test_reset();
    bus.prog_valid = 0; bus.prog_sel = 0; bus.prog_addr = '0; bus.prog_data = '0; bus.run = 0;
    bus.i_addr = '0; bus.d_addr = '0; bus.d_dataout = '0; bus.d_we = 0;
    reset = 1'b1; repeat (2) @(posedge clock); #1;
    n_tests++; if ({bus.prog_ready, bus.cpu_start, bus.halted, bus.prot_err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {bus.prog_ready, bus.cpu_start, bus.halted, bus.prot_err}); end
    n_tests++; if (bus.i_datain !== '0 || bus.d_datain !== '0) begin n_fail++; $display("FAIL reset_data got %h/%h exp 0/0", bus.i_datain, bus.d_datain); end
    n_tests++; if (bus.cycle_count !== '0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.cycle_count); end
    reset = 1'b0; repeat (2) @(posedge clock); #1;
    for (int i = 0; i < IMEM_D; i++) host_wr(1'b0, i, rnd_word());
    for (int i = 0; i < DMEM_D; i++) host_wr(1'b1, i, 16'($urandom));
  endtask

  task automatic test_program();
    int nc;
    host_wr(1'b0, 0, 16'h89CB);
    for (int i = 1; i < 4; i++) host_wr(1'b0, i, 16'h0000);
    host_wr(1'b0, 4, 16'h0800);
    script_default(1'b0, 1'b0);
    run_cpu("program", 20, 1'b1, 1'b0, 1'b0, '0, '0, nc);
    n_tests++; if (nc !== 5) begin n_fail++; $display("FAIL program_cycles got %0d exp 5", nc); end
    check_halted("program", nc);
    go_idle("program");
  endtask

  task automatic test_load_latency();
    int nc;
    host_wr(1'b1, 8'h10, 16'h00AB);
    load_prog(10);
    script_default(1'b0, 1'b0);
    for (int k = 0; k < 128; k++) s_daddr[k] = (k == 0) ? 8'h10 : 8'h30;
    run_cpu("load_lat", 40, 1'b1, 1'b0, 1'b0, '0, '0, nc);
    check_halted("load_lat", nc);
    go_idle("load_lat");
  endtask

  task automatic test_store_load();
    int nc;
    host_wr(1'b1, 8'h21, 16'h1111);
    load_prog(10);
    script_default(1'b0, 1'b0);
    for (int k = 0; k < 128; k++) s_daddr[k] = 8'h40;
    s_daddr[0] = 8'h20; s_we[0] = 1'b1; s_dout[0] = 16'h3C00;
    s_daddr[1] = 8'h20;
    s_daddr[2] = 8'h21; s_we[2] = 1'b1; s_dout[2] = 16'h2222;
    s_daddr[3] = 8'h21;
    run_cpu("store_load", 40, 1'b1, 1'b0, 1'b0, '0, '0, nc);
    check_halted("store_load", nc);
    go_idle("store_load");
  endtask

  task automatic test_oob();
    int nc;
    host_wr(1'b0, 8'hFF, 16'h0800);
    load_prog(8);
    script_default(1'b0, 1'b0);
    s_iaddr[3] = 8'h7F; s_iaddr[4] = 8'hFF;
    run_cpu("oob", 40, 1'b1, 1'b0, 1'b0, '0, '0, nc);
    n_tests++; if (nc !== 9) begin n_fail++; $display("FAIL oob_cycles got %0d exp 9", nc); end
    check_halted("oob", nc);
    go_idle("oob");
  endtask

  task automatic test_prog_during_run();
    int nc;
    load_prog(12);
    script_default(1'b0, 1'b0);
    run_cpu("spam", 40, 1'b1, 1'b1, 1'b0, '0, '0, nc);
    check_halted("spam", nc);
    go_idle("spam");
    script_default(1'b0, 1'b0);
    for (int k = 0; k < 128; k++) s_daddr[k] = 8'($urandom_range(0, 12));
    run_cpu("spam_rerun", 40, 1'b1, 1'b0, 1'b0, '0, '0, nc);
    n_tests++; if (nc !== 13) begin n_fail++; $display("FAIL spam_rerun_cycles got %0d exp 13", nc); end
    check_halted("spam_rerun", nc);
    go_idle("spam_rerun");
  endtask

  task automatic test_back_to_back();
    int nc;
    load_prog(8);
    script_default(1'b0, 1'b0);
    s_daddr[0] = 8'h33;
    run_cpu("b2b", 40, 1'b1, 1'b0, 1'b1, 8'h33, 16'h4242, nc);
    check_halted("b2b", nc);
    go_idle("b2b");
  endtask

  task automatic test_reset_mid_run();
    int nc;
    load_prog(15);
    script_default(1'b1, 1'b0);
    run_cpu("mid_reset", 6, 1'b0, 1'b0, 1'b0, '0, '0, nc);
    reset = 1'b1; @(posedge clock); #1;
    n_tests++; if (bus.i_datain !== '0 || bus.cycle_count !== '0 || bus.d_datain !== '0) begin n_fail++; $display("FAIL mid_reset_vals got i=%h cnt=%0d d=%h exp 0", bus.i_datain, bus.cycle_count, bus.d_datain); end
    n_tests++; if ({bus.prog_ready, bus.cpu_start, bus.halted, bus.prot_err} !== 4'b0) begin n_fail++; $display("FAIL mid_reset_flags got %b exp 0000", {bus.prog_ready, bus.cpu_start, bus.halted, bus.prot_err}); end
    reset = 1'b0; perr_m = 1'b0;
    @(posedge clock); #1;
    run_cpu("rerun", 40, 1'b1, 1'b0, 1'b0, '0, '0, nc);
    n_tests++; if (nc !== 16) begin n_fail++; $display("FAIL rerun_cycles got %0d exp 16", nc); end
    check_halted("rerun", nc);
    go_idle("rerun");
  endtask

  task automatic test_saturation();
    int nc;
    load_prog(70);
    script_default(1'b1, 1'b0);
    run_cpu("saturate", 100, 1'b1, 1'b0, 1'b0, '0, '0, nc);
    check_halted("saturate", nc);
    go_idle("saturate");
  endtask

  task automatic test_prot();
    int nc;
    host_wr(1'b1, 8'h05, 16'h0505);
    host_wr(1'b1, 8'h10, 16'h1010);
    load_prog(10);
    script_default(1'b0, 1'b0);
    for (int k = 0; k < 128; k++) s_daddr[k] = 8'h80;
    s_daddr[0] = 8'h05; s_we[0] = 1'b1; s_dout[0] = 16'hDEAD;
    s_daddr[1] = 8'h05;
    s_daddr[2] = 8'h10; s_we[2] = 1'b1; s_dout[2] = 16'hBEEF;
    s_daddr[3] = 8'h10;
    run_cpu("prot", 40, 1'b1, 1'b0, 1'b0, '0, '0, nc);
    check_halted("prot", nc);
    n_tests++; if (bus.prot_err !== PROT) begin n_fail++; $display("FAIL prot_sticky got %b exp %b", bus.prot_err, PROT); end
    go_idle("prot");
    n_tests++; if (bus.prot_err !== PROT) begin n_fail++; $display("FAIL prot_sticky_idle got %b exp %b", bus.prot_err, PROT); end
  endtask

  task automatic test_random();
    int nc, h;
    for (int it = 0; it < 5; it++) begin
      h = $urandom_range(6, 40);
      load_prog(h);
      script_default(1'b1, 1'b1);
      run_cpu("random", 60, 1'b1, 1'b0, 1'b0, '0, '0, nc);
      n_tests++; if (nc !== h + 1) begin n_fail++; $display("FAIL random_cycles got %0d exp %0d", nc, h + 1); end
      check_halted("random", nc);
      go_idle("random");
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_load_latency();
    test_store_load();
    test_oob();
    test_prog_during_run();
    test_back_to_back();
    test_reset_mid_run();
    test_saturation();
    test_prot();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pcpu_mem_sys.md
Name: pcpu_mem_sys

Overview:
Parametrised instruction/data memory subsystem for the pipelined CPU (pcpu), replacing hand-sequenced i_datain/d_datain stimulus with loadable memories.
- Host preloads program and data through a valid/ready port, then pulses run.
- The block issues the CPU start pulse, serves fetches and loads/stores with configurable data-read latency, and detects HALT.
- Freezes a cycle counter for performance reporting; sits between pcpu and bench/host.

Parameters:
DATA_W, 16, instruction/data word width (opcode in bits [DATA_W-1:DATA_W-5])
ADDR_W, 8, instruction and data address width
IMEM_DEPTH, 256, instruction words (<= 2**ADDR_W)
DMEM_DEPTH, 256, data words (<= 2**ADDR_W)
RD_LAT, 1, data read latency in cycles, legal 1..4
CNT_W, 16, cycle counter width
PROT_BASE, 16, first writable data address (used only with feature macro)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
prog_valid  in  1  host write request
prog_ready  out  1  host write accepted when both high
prog_sel  in  1  0 = imem, 1 = dmem
prog_addr  in  ADDR_W  host write address
prog_data  in  DATA_W  host write data
run  in  1  one-cycle request to start execution
cpu_start  out  1  start pulse to pcpu
i_addr  in  ADDR_W  CPU fetch address
i_datain  out  DATA_W  fetched instruction
d_addr  in  ADDR_W  CPU data address
d_dataout  in  DATA_W  CPU store data
d_we  in  1  CPU store strobe
d_datain  out  DATA_W  load data to CPU
halted  out  1  HALT seen, execution stopped
cycle_count  out  CNT_W  cycles spent in RUN
prot_err  out  1  sticky protection violation (feature only, else tied 0)

Behaviour:
- Reset values: prog_ready=0, cpu_start=0, i_datain=0, d_datain=0, halted=0, cycle_count=0, prot_err=0, state=IDLE. Memory contents are not cleared.
- FSM states: IDLE, RUN, HALTED.
  - IDLE -> RUN on run=1: cpu_start=1 for exactly that next cycle.
  - RUN -> HALTED when i_datain opcode == 5'b00001; transition on the following edge.
  - HALTED -> IDLE on run=1: cpu_start not asserted, cycle_count cleared. A second run then starts RUN.
- prog_ready=1 only in IDLE and HALTED. Write occurs on the edge where prog_valid&&prog_ready.
- Address bounds: prog_addr >= depth of the selected memory -> handshake completes, write dropped.
- i_datain = imem[i_addr], combinational, 0 when i_addr >= IMEM_DEPTH. Forced to 0 (NOP) outside RUN.
- Store: in RUN, d_we=1 writes d_dataout to dmem[d_addr] at the edge. Out-of-range addresses ignored. d_we ignored outside RUN.
- Load: d_datain = dmem[d_addr] sampled RD_LAT edges earlier, via a shift pipeline.
  - Same-cycle write and read of the same address returns the old data.
  - Pipeline flushes to 0 on reset and on RUN exit.
- cycle_count: increments every RUN cycle, including the HALT-detect cycle. Saturates at all-ones. Holds in HALTED.
- halted=1 exactly while in HALTED.
- Reset mid-RUN: immediate return to IDLE with all outputs at reset values. Memory contents preserved.
- Simultaneous run and prog_valid in IDLE: write is accepted and run is honoured on the same edge.

Optional Feature:
PCPU_MEM_PROT_EN
- Defined: CPU stores with d_addr < PROT_BASE are dropped and set prot_err (sticky until reset). Host writes are unaffected.
- Undefined: all in-range stores are accepted; prot_err is tied 0.

Decomposition:
- Package pcpu_mem_pkg holds:
  - opcode constants (NOP 5'b00000, HALT 5'b00001, LOAD 5'b00010, STORE 5'b00011)
  - FSM state encoding (IDLE/RUN/HALTED)
  - RD_LAT legal-range constants
- One sub-module, pcpu_mem_rdpipe: parametrised DATA_W x RD_LAT delay line with flush input.

Test Plan:
- Load imem[0]=LDIH gr1 0xCB, imem[1..3]=NOP, imem[4]=HALT; pulse run -> cpu_start high one cycle, halted=1 after HALT fetch, cycle_count frozen at a stable value, prog_ready returns to 1.
- Preload dmem[0x10]=0x00AB, RD_LAT=3; CPU LOAD from 0x10 -> d_datain=0x00AB exactly 3 cycles after d_addr=0x10, 0 before.
- CPU STORE 0x3C00 to 0x20, then LOAD 0x20 -> returns 0x3C00. Same-cycle store/load to 0x21 returns the prior value.
- prog_valid during RUN -> prog_ready=0, memory unchanged. Write to prog_addr=0xFF with IMEM_DEPTH=128 -> accepted, no write.
- Assert reset for one cycle mid-RUN -> state IDLE, cycle_count=0, i_datain=0. Re-run executes the preserved program identically.
- With PCPU_MEM_PROT_EN, PROT_BASE=16: store to 0x05 -> dmem[0x05] unchanged, prot_err=1 and stays set. Store to 0x10 -> succeeds.
